// File: rtl/dense_argmax.sv
`default_nettype none
// ============================================================================
// Module   : dense_argmax
// Brief    : Streaming argmax over NUM_CLASSES signed dense-layer sums per frame,
//            with a valid/ready result hold. Define DENSE_ARGMAX_BIAS_EN for
//            per-class bias registers.
// Revision : 1.0
// ============================================================================
module dense_argmax #(
    parameter int IN_WIDTH    = 32,
    parameter int NUM_CLASSES = 10,
    parameter int CLS_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start_in,
    input  logic                 frame_end_in,
    input  logic [IN_WIDTH-1:0]  dense_sum_in,
    input  logic                 dense_valid_in,
    output logic [CLS_WIDTH-1:0] class_out,
    output logic [IN_WIDTH:0]    score_out,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 short_err,
    output logic                 overrun_err
`ifdef DENSE_ARGMAX_BIAS_EN
    ,
    input  logic                 bias_wr_en,
    input  logic [CLS_WIDTH-1:0] bias_wr_addr,
    input  logic [IN_WIDTH-1:0]  bias_wr_data
`endif
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_COLLECT = 2'd1;
    localparam logic [1:0] c_ST_HOLD    = 2'd2;

    localparam logic [CLS_WIDTH-1:0] c_LAST_IDX = CLS_WIDTH'(NUM_CLASSES - 1);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [CLS_WIDTH-1:0]       r_cnt;
    logic [CLS_WIDTH-1:0]       r_max_cls;
    logic signed [IN_WIDTH:0]   r_max_score;
    logic                       r_short_err;
    logic                       r_overrun_err;

    logic                       w_start_ok;
    logic                       w_take;
    logic [CLS_WIDTH-1:0]       w_idx;
    logic                       w_first;
    logic                       w_last;
    logic                       w_short;
    logic signed [IN_WIDTH:0]   w_score;

    // A frame start is honoured everywhere except while a result is waiting.
    assign w_start_ok = frame_start_in && (r_state != c_ST_HOLD);
    assign w_take     = dense_valid_in && (w_start_ok || (r_state == c_ST_COLLECT));
    assign w_idx      = w_start_ok ? '0 : r_cnt;
    assign w_first    = (w_idx == '0);
    assign w_last     = (w_idx == c_LAST_IDX);
    assign w_short    = (r_state == c_ST_COLLECT) && frame_end_in && !frame_start_in
                        && !(w_take && w_last);

`ifdef DENSE_ARGMAX_BIAS_EN
    logic [IN_WIDTH-1:0] w_bias [2**CLS_WIDTH];

    // Slots beyond NUM_CLASSES are constant zero, so out-of-range writes vanish.
    for (genvar gi = 0; gi < 2**CLS_WIDTH; gi++) begin : g_bias
        if (gi < NUM_CLASSES) begin : g_reg
            logic [IN_WIDTH-1:0] r_bias;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_bias <= '0;
                else if (bias_wr_en && (bias_wr_addr == CLS_WIDTH'(gi)))
                    r_bias <= bias_wr_data;
            end
            assign w_bias[gi] = r_bias;
        end else begin : g_zero
            assign w_bias[gi] = '0;
        end
    end

    assign w_score = $signed({dense_sum_in[IN_WIDTH-1], dense_sum_in})
                   + $signed({w_bias[w_idx][IN_WIDTH-1], w_bias[w_idx]});
`else
    assign w_score = $signed({dense_sum_in[IN_WIDTH-1], dense_sum_in});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok)
                    w_state_nxt = c_ST_COLLECT;
            end
            c_ST_COLLECT: begin
                if (w_take && w_last)
                    w_state_nxt = c_ST_HOLD;
                else if (frame_start_in)
                    w_state_nxt = c_ST_COLLECT;
                else if (frame_end_in)
                    w_state_nxt = c_ST_IDLE;
            end
            c_ST_HOLD: begin
                if (result_ready)
                    w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_max_cls     <= '0;
            r_max_score   <= '0;
            r_short_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_short_err <= 1'b0;
            if (w_start_ok) begin
                r_cnt         <= '0;
                r_max_cls     <= '0;
                r_max_score   <= '0;
                r_overrun_err <= 1'b0;
            end
            // Strict compare keeps the lower index on ties.
            if (w_take) begin
                if (w_first || (w_score > r_max_score)) begin
                    r_max_score <= w_score;
                    r_max_cls   <= w_idx;
                end
                r_cnt <= w_last ? '0 : w_idx + CLS_WIDTH'(1);
            end else if (w_short) begin
                r_short_err <= 1'b1;
                r_cnt       <= '0;
            end
            if ((r_state == c_ST_HOLD) && (dense_valid_in || frame_start_in))
                r_overrun_err <= 1'b1;
        end
    end

    // The running max freezes in HOLD, so it doubles as the result register.
    always_comb begin
        result_valid = (r_state == c_ST_HOLD);
        class_out    = r_max_cls;
        score_out    = r_max_score;
        short_err    = r_short_err;
        overrun_err  = r_overrun_err;
    end

endmodule
`default_nettype wire

// File: doc/dense_argmax.md
DENSE_ARGMAX -- requirements
Module: dense_argmax

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of the signed dense sum from the accumulator.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of dense output neurons per frame (2..16).
REQ-003 SHALL have parameter CLS_WIDTH, default 4, class index width (2**CLS_WIDTH >= NUM_CLASSES).
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port frame_start_in  input  1  starts a new classification frame.
REQ-007 SHALL have port frame_end_in  input  1  marks end of upstream frame.
REQ-008 SHALL have port dense_sum_in  input  IN_WIDTH  signed neuron sum, two's complement.
REQ-009 SHALL have port dense_valid_in  input  1  dense_sum_in qualifier, one neuron per pulse, class order 0..NUM_CLASSES-1.
REQ-010 SHALL have port class_out  output  CLS_WIDTH  index of winning neuron.
REQ-011 SHALL have port score_out  output  IN_WIDTH+1  signed winning score.
REQ-012 SHALL have port result_valid  output  1  result available.
REQ-013 SHALL have port result_ready  input  1  downstream accepts result.
REQ-014 SHALL have port short_err  output  1  one-cycle pulse: frame ended with fewer than NUM_CLASSES samples.
REQ-015 SHALL have port overrun_err  output  1  sticky: sample or frame start arrived while result unconsumed.

Function
REQ-016 SHALL implement FSM IDLE, COLLECT, HOLD; valid samples in IDLE without frame_start_in are ignored.
REQ-017 SHALL, on frame_start_in in IDLE or COLLECT, clear class counter and running max, enter COLLECT; a dense_valid_in in the same cycle is class 0 of the new frame.
REQ-018 SHALL, per valid sample in COLLECT, form score = sign-extend(dense_sum_in) to IN_WIDTH+1 (plus bias per REQ-029), tag with counter value, increment counter.
REQ-019 SHALL load the first sample of a frame as max unconditionally; later samples replace max only if strictly greater (ties keep lower index).
REQ-020 SHALL, in the cycle after the NUM_CLASSES-th sample, present class_out/score_out with result_valid=1 and enter HOLD (latency 1 cycle).
REQ-021 SHALL hold class_out, score_out, result_valid stable while result_valid=1 and result_ready=0.
REQ-022 SHALL, on result_valid and result_ready both high, complete transfer; next cycle result_valid=0, state IDLE.
REQ-023 SHALL, on frame_end_in in COLLECT with counter < NUM_CLASSES, pulse short_err one cycle, discard partial result, return to IDLE; frame_end_in elsewhere has no effect.
REQ-024 SHALL, in HOLD, drop dense_valid_in and frame_start_in and set overrun_err; overrun_err clears only on an accepted frame_start_in or reset.
REQ-025 SHALL treat frame_start_in in COLLECT as abort-and-restart, no short_err.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, class_out 0, score_out 0, result_valid 0, short_err 0, overrun_err 0.
REQ-027 SHALL, on reset mid-COLLECT or HOLD, lose the pending frame/result; first action after release requires frame_start_in.

Configuration
REQ-028 SHALL compile per-class bias support only when macro DENSE_ARGMAX_BIAS_EN is defined.
REQ-029 SHALL, with DENSE_ARGMAX_BIAS_EN, add ports bias_wr_en input 1, bias_wr_addr input CLS_WIDTH, bias_wr_data input IN_WIDTH; NUM_CLASSES bias registers reset to 0; score = sext(sum)+sext(bias) in IN_WIDTH+1 bits; writes with addr >= NUM_CLASSES ignored; a write affects samples in later cycles only.
REQ-030 SHALL, without DENSE_ARGMAX_BIAS_EN, omit bias ports and registers; score = sext(dense_sum_in).

Verification
REQ-031 SHALL cover: frame_start, sums {5,-3,9,9,0,1,2,3,4,-8} with result_ready=1 -> one cycle after 10th sample class_out=2, score_out=9, result_valid one cycle.
REQ-032 SHALL cover: all sums negative {-10..-1 ascending} -> class_out=9, score_out=-1.
REQ-033 SHALL cover: result_ready=0 for 20 cycles, extra dense_valid_in in HOLD -> outputs stable, overrun_err=1 until next frame_start_in.
REQ-034 SHALL cover: 6 samples then frame_end_in -> short_err one-cycle pulse, no result_valid, state IDLE.
REQ-035 SHALL cover: rst_n asserted after 4 samples -> all outputs 0 immediately; new full frame after release classifies correctly.
REQ-036 SHALL cover (DENSE_ARGMAX_BIAS_EN): bias[3]=100, all sums 0 -> class_out=3, score_out=100.
